// File: rtl/display_pkg.sv
// Shared types and constants for the multiplexed seven-segment display scanner.
package display_pkg;

  typedef enum logic {
    SHOW = 1'b0,
    GAP  = 1'b1
  } scan_state_e;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Counter width for a count range of n values; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/display.sv
// Combinational hex-to-seven-segment decoder, active-low, bit order g..a.
module display
  import display_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_n_o
);

  always_comb begin
    seg_n_o = SEG_OFF;
    unique case (hex_i)
      4'h0: seg_n_o = 7'h40;
      4'h1: seg_n_o = 7'h79;
      4'h2: seg_n_o = 7'h24;
      4'h3: seg_n_o = 7'h30;
      4'h4: seg_n_o = 7'h19;
      4'h5: seg_n_o = 7'h12;
      4'h6: seg_n_o = 7'h02;
      4'h7: seg_n_o = 7'h78;
      4'h8: seg_n_o = 7'h00;
      4'h9: seg_n_o = 7'h10;
      4'hA: seg_n_o = 7'h08;
      4'hB: seg_n_o = 7'h03;
      4'hC: seg_n_o = 7'h46;
      4'hD: seg_n_o = 7'h21;
      4'hE: seg_n_o = 7'h06;
      4'hF: seg_n_o = 7'h0E;
      default: seg_n_o = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Scans N_DIGITS common-anode digits through one decoder, with dead-time between
// digits, leading-zero blanking and a shadow register committed only at frame wrap.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int N_DIGITS    = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int GAP_CYCLES  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*N_DIGITS-1:0]   value,
  input  logic [N_DIGITS-1:0]     dp_in,
  input  logic                    blank_lz,
  output logic [6:0]              seg_n,
  output logic                    dp_n,
  output logic [N_DIGITS-1:0]     dig_n,
  output logic                    frame_done,
  output logic                    pending,
  output scan_state_e             state_dbg
);

  localparam int W     = 4 * N_DIGITS;
  localparam int DIV_W = cnt_width(REFRESH_DIV);
  localparam int GAP_W = cnt_width(GAP_CYCLES);
  localparam int IDX_W = cnt_width(N_DIGITS);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

  scan_state_e          state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [GAP_W-1:0]     gap_q, gap_d;

  logic [W-1:0]         act_val_q, act_val_d, sh_val_q, sh_val_d;
  logic                 act_blz_q, act_blz_d, sh_blz_q, sh_blz_d;
  logic [N_DIGITS-1:0]  act_dp_q, act_dp_d, sh_dp_q, sh_dp_d;
  logic                 pending_q, pending_d;

  logic [6:0]           seg_q, seg_d;
  logic                 dp_q, dp_d;
  logic [N_DIGITS-1:0]  dig_q, dig_d;
  logic                 fd_q, fd_d;

  logic                 wrap;
  logic                 zero_run;
  logic [N_DIGITS-1:0]  blank_mask;
  logic [3:0]           cur_nib;
  logic                 cur_blank;
  logic                 cur_dp;
  logic [N_DIGITS-1:0]  cur_sel_n;
  logic [6:0]           dec_seg_n;

  display u_display (
    .hex_i   (cur_nib),
    .seg_n_o (dec_seg_n)
  );

  // A digit is blanked when it and every more-significant nibble are zero.
  always_comb begin
    zero_run   = 1'b1;
    blank_mask = '0;
    for (int k = N_DIGITS - 1; k >= 1; k--) begin
      zero_run      = zero_run & (act_val_q[4*k +: 4] == 4'h0);
      blank_mask[k] = act_blz_q & zero_run;
    end
  end

  always_comb begin
    cur_nib   = '0;
    cur_blank = 1'b0;
    cur_dp    = 1'b0;
    cur_sel_n = '1;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        cur_nib      = act_val_q[4*k +: 4];
        cur_blank    = blank_mask[k];
        cur_dp       = act_dp_q[k];
        cur_sel_n[k] = 1'b0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    div_d   = div_q;
    gap_d   = gap_q;
    wrap    = 1'b0;
    unique case (state_q)
      SHOW: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          wrap  = (idx_q == IDX_LAST);
          idx_d = wrap ? '0 : idx_q + 1'b1;
          if (GAP_CYCLES > 0) state_d = GAP;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          state_d = SHOW;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = SHOW;
    endcase
  end

  // A load landing on the wrap cycle goes straight to the active set.
  always_comb begin
    act_val_d = act_val_q;
    act_blz_d = act_blz_q;
    act_dp_d  = act_dp_q;
    sh_val_d  = sh_val_q;
    sh_blz_d  = sh_blz_q;
    sh_dp_d   = sh_dp_q;
    pending_d = pending_q;
    if (load) begin
      sh_val_d  = value;
      sh_blz_d  = blank_lz;
      sh_dp_d   = dp_in;
      pending_d = 1'b1;
    end
    if (wrap) begin
      if (load) begin
        act_val_d = value;
        act_blz_d = blank_lz;
        act_dp_d  = dp_in;
        pending_d = 1'b0;
      end else if (pending_q) begin
        act_val_d = sh_val_q;
        act_blz_d = sh_blz_q;
        act_dp_d  = sh_dp_q;
        pending_d = 1'b0;
      end
    end
  end

  always_comb begin
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    dig_d = '1;
    fd_d  = wrap;
    if (state_q == SHOW && !cur_blank) begin
      seg_d = dec_seg_n;
      dp_d  = ~cur_dp;
      dig_d = cur_sel_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= SHOW;
      idx_q     <= '0;
      div_q     <= '0;
      gap_q     <= '0;
      act_val_q <= '0;
      act_blz_q <= 1'b0;
      act_dp_q  <= '0;
      sh_val_q  <= '0;
      sh_blz_q  <= 1'b0;
      sh_dp_q   <= '0;
      pending_q <= 1'b0;
      seg_q     <= SEG_OFF;
      dp_q      <= 1'b1;
      dig_q     <= '1;
      fd_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      div_q     <= div_d;
      gap_q     <= gap_d;
      act_val_q <= act_val_d;
      act_blz_q <= act_blz_d;
      act_dp_q  <= act_dp_d;
      sh_val_q  <= sh_val_d;
      sh_blz_q  <= sh_blz_d;
      sh_dp_q   <= sh_dp_d;
      pending_q <= pending_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
      dig_q     <= dig_d;
      fd_q      <= fd_d;
    end
  end

  assign seg_n      = seg_q;
  assign dp_n       = dp_q;
  assign dig_n      = dig_q;
  assign frame_done = fd_q;
  assign pending    = pending_q;
  assign state_dbg  = state_q;

endmodule
